// File: rtl/rem_pkg.sv
// Shared state/mode codes and iteration count for the rem_mul modular arithmetic unit.
package rem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic MODE_REM = 1'b0;
  localparam logic MODE_MUL = 1'b1;

  // REM consumes all 2W dividend bits; MULMOD walks the W bits of A.
  function automatic int unsigned iter_cnt(input logic mode, input int unsigned w);
    return (mode == MODE_MUL) ? w : 2 * w;
  endfunction

endpackage

// File: rtl/mod_step.sv
// One MSB-first iteration of the remainder / interleaved multiply-reduce recurrence.
module mod_step
  import rem_pkg::*;
#(
  parameter int unsigned MSB = 7
) (
  input  logic [MSB+2:0] i_r,
  input  logic           i_bit,
  input  logic [MSB:0]   i_b,
  input  logic [MSB:0]   i_n,
  input  logic           i_mode,
  output logic [MSB+2:0] o_r
);

  localparam int unsigned W  = MSB + 1;
  localparam int unsigned RW = W + 2;

  logic [RW-1:0] w_t;
  logic [RW-1:0] w_s1;
  logic [RW-1:0] w_s2;

  // Incoming r is always < N, so the dropped top bit of each shift is zero.
  always_comb begin
    w_t  = '0;
    w_s1 = '0;
    w_s2 = '0;
    if (i_mode == MODE_MUL) begin
      w_t = RW'({i_r, 1'b0}) + (i_bit ? RW'(i_b) : RW'(0));
    end else begin
      w_t = RW'({i_r, i_bit});
    end
    w_s1 = (w_t >= RW'(i_n)) ? (w_t - RW'(i_n)) : w_t;
    w_s2 = ((i_mode == MODE_MUL) && (w_s1 >= RW'(i_n))) ? (w_s1 - RW'(i_n)) : w_s1;
    o_r  = w_s2;
  end

endmodule

// File: rtl/rem_mul.sv
// Modular arithmetic unit: D mod N or (A*B) mod N, two-phase req / one-cycle ack handshake.
module rem_mul
  import rem_pkg::*;
#(
  parameter int unsigned MSB    = 7,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               req,
  input  logic [2*MSB+1:0]   rx_data_1,
  input  logic [MSB:0]       rx_data_2,
  output logic               ack,
  output logic               err,
  output logic [MSB:0]       tx_data,
  output logic [1:0]         cst,
  output logic [1:0]         nst
);

  localparam int unsigned W     = MSB + 1;
  localparam int unsigned RW    = W + 2;
  localparam int unsigned CNT_W = $clog2(2 * W);

  state_t             r_cst;
  state_t             w_nst;
  logic               r_req_q;
  logic               r_mode;
  logic [2*W-1:0]     r_d;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_n;
  logic [RW-1:0]      r_r;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_tx;
  logic               r_err;

  logic               w_mode;
  logic               w_start;
  logic               w_illegal;
  logic [RW-1:0]      w_step;

  // With the multiplier disabled the mode pin is ignored and the MUL path folds away.
  assign w_mode    = MUL_EN ? mode : MODE_REM;
  assign w_start   = (r_cst == ST_IDLE) && enable && (req != r_req_q);
  assign w_illegal = (rx_data_2 == '0) ||
                     ((w_mode == MODE_MUL) && (rx_data_1[W-1:0] >= rx_data_2));

  mod_step #(.MSB(MSB)) u_step (
    .i_r    (r_r),
    .i_bit  (r_d[2*W-1]),
    .i_b    (r_b),
    .i_n    (r_n),
    .i_mode (r_mode),
    .o_r    (w_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cst <= ST_IDLE;
    end else begin
      r_cst <= w_nst;
    end
  end

  // Next-state decode; enable low overrides everything.
  always_comb begin
    w_nst = r_cst;
    if (!enable) begin
      w_nst = ST_IDLE;
    end else begin
      case (r_cst)
        ST_IDLE: if (w_start) w_nst = w_illegal ? ST_ERR : ST_CALC;
        ST_CALC: if (r_cnt == '0) w_nst = ST_DONE;
        ST_DONE: w_nst = ST_IDLE;
        ST_ERR:  w_nst = ST_IDLE;
        default: w_nst = ST_IDLE;
      endcase
    end
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q <= 1'b0;
      r_mode  <= MODE_REM;
      r_d     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!enable || w_start) begin
        r_req_q <= req;
      end
      if (w_start) begin
        r_mode <= w_mode;
        r_d    <= rx_data_1;
        r_b    <= rx_data_1[W-1:0];
        r_n    <= rx_data_2;
        r_r    <= '0;
        r_cnt  <= CNT_W'(iter_cnt(w_mode, W) - 1);
        if (w_illegal) begin
          r_tx  <= '0;
          r_err <= 1'b1;
        end
      end else if (enable && (r_cst == ST_CALC)) begin
        r_r   <= w_step;
        r_d   <= r_d << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_tx  <= w_step[W-1:0];
          r_err <= 1'b0;
        end
      end
    end
  end

  assign ack     = (r_cst == ST_DONE) || (r_cst == ST_ERR);
  assign err     = r_err;
  assign tx_data = r_tx;
  assign cst     = r_cst;
  assign nst     = w_nst;

endmodule

// File: tb/tb_rem_mul.sv
// Scoreboard bench for rem_mul (MSB=7): directed corner cases plus randomized ops vs an integer model.
module tb_rem_mul;

  localparam int unsigned MSB = 7;

  typedef struct packed {
    logic       err;
    logic [7:0] tx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        mode;
  logic        req;
  logic [15:0] rx_data_1;
  logic [7:0]  rx_data_2;
  logic        ack;
  logic        err;
  logic [7:0]  tx_data;
  logic [1:0]  cst;
  logic [1:0]  nst;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ack    = 0;
  exp_t sb[$];
  exp_t mon_e;

  rem_mul #(.MSB(MSB), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .req       (req),
    .rx_data_1 (rx_data_1),
    .rx_data_2 (rx_data_2),
    .ack       (ack),
    .err       (err),
    .tx_data   (tx_data),
    .cst       (cst),
    .nst       (nst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden result from plain integer arithmetic.
  function automatic exp_t model(input logic m, input logic [15:0] d, input logic [7:0] n);
    int unsigned a, b, nn, dd;
    exp_t e;
    dd = d;
    a  = dd >> 8;
    b  = dd & 32'hFF;
    nn = n;
    if (nn == 0 || (m && b >= nn)) begin
      e.err = 1'b1;
      e.tx  = 8'h00;
    end else begin
      e.err = 1'b0;
      e.tx  = 8'(m ? (a * b) % nn : dd % nn);
    end
    return e;
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ack) begin
      n_ack++;
      if (sb.size() == 0) begin
        chk("spurious_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("err", int'(err), int'(mon_e.err));
        chk("tx_data", int'(tx_data), int'(mon_e.tx));
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge where ack is seen.
  // lat counts clock edges after the start edge until ack is visible.
  task automatic run_op(input logic m, input logic [15:0] d, input logic [7:0] n,
                        input logic e_err, input logic [7:0] e_tx, input int exp_lat);
    exp_t e;
    int   lat;
    e.err = e_err;
    e.tx  = e_tx;
    sb.push_back(e);
    mode      = m;
    rx_data_1 = d;
    rx_data_2 = n;
    req       = ~req;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack) chk("ack_timeout", 0, 1);
    else      chk("latency", lat, exp_lat);
  endtask

  task automatic run_model(input logic m, input logic [15:0] d, input logic [7:0] n);
    exp_t e;
    e = model(m, d, n);
    run_op(m, d, n, e.err, e.tx, e.err ? 0 : (m ? 8 : 16));
  endtask

  initial begin
    int   a0;
    exp_t e;
    logic m;
    logic [7:0]  n;
    logic [15:0] d;

    rst = 1'b1; enable = 1'b1; mode = 1'b0; req = 1'b0;
    rx_data_1 = '0; rx_data_2 = '0;
    @(negedge clk);
    chk("rst_cst", int'(cst), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_tx", int'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed REM and MULMOD.
    run_op(1'b0, 16'hFFFF, 8'hFB, 1'b0, 8'h18, 16);
    @(negedge clk);
    run_op(1'b1, 16'hC864, 8'hFB, 1'b0, 8'hAB, 8);
    @(negedge clk);

    // Illegal operands: ERR visible right after the start edge, then back to IDLE.
    chk("err_pre_cst", int'(cst), 0);
    run_op(1'b0, 16'h1234, 8'h00, 1'b1, 8'h00, 0);
    chk("err_cst_rem", int'(cst), 3);
    @(negedge clk);
    chk("err_post_cst", int'(cst), 0);
    run_op(1'b1, 16'h05FB, 8'hFB, 1'b1, 8'h00, 0);
    chk("err_cst_mul", int'(cst), 3);
    @(negedge clk);
    run_op(1'b1, 16'h0503, 8'h00, 1'b1, 8'h00, 0);
    @(negedge clk);

    // Boundaries: N==1, zero dividend / multiplier, B just below N.
    run_model(1'b0, 16'hFFFF, 8'h01);
    @(negedge clk);
    run_model(1'b1, 16'hFF00, 8'h01);
    @(negedge clk);
    run_model(1'b0, 16'h0000, 8'h35);
    @(negedge clk);
    run_model(1'b1, 16'h0033, 8'h35);
    @(negedge clk);
    run_op(1'b1, 16'hFFFA, 8'hFB, 1'b0, 8'd247, 8);
    @(negedge clk);
    run_op(1'b0, 16'h0100, 8'h07, 1'b0, 8'h04, 16);
    @(negedge clk);

    // Abort mid-CALC: no ack, previous result kept, no restart on re-enable.
    a0 = n_ack;
    mode = 1'b0; rx_data_1 = 16'hABCD; rx_data_2 = 8'h11; req = ~req;
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("abort_in_calc", int'(cst), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_cst", int'(cst), 0);
    chk("abort_ack", int'(ack), 0);
    chk("abort_tx", int'(tx_data), 4);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (25) @(negedge clk);
    chk("reenable_cst", int'(cst), 0);
    chk("abort_no_ack", n_ack - a0, 0);

    // Asynchronous reset between edges while in CALC.
    rx_data_1 = 16'h0100; rx_data_2 = 8'h07; req = ~req;
    @(posedge clk);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cst", int'(cst), 0);
    chk("arst_ack", int'(ack), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_tx", int'(tx_data), 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_model(1'b1, 16'hC864, 8'hFB);
    @(negedge clk);

    // Randomized back-to-back operations.
    for (int i = 0; i < 1000; i++) begin
      m = 1'($urandom_range(0, 1));
      n = 8'($urandom_range(1, 255));
      d = 16'($urandom);
      if (m) d[7:0] = 8'($urandom_range(0, int'(n) - 1));
      run_model(m, d, n);
      @(negedge clk);
    end

    // One toggle while busy queues exactly one further operation.
    a0 = n_ack;
    e  = model(1'b0, 16'hBEEF, 8'h3D);
    mode = 1'b0; rx_data_1 = 16'hBEEF; rx_data_2 = 8'h3D;
    sb.push_back(e);
    req = ~req;
    @(posedge clk);
    repeat (4) @(negedge clk);
    sb.push_back(e);
    req = ~req;
    repeat (60) @(negedge clk);
    chk("busy_toggle_acks", n_ack - a0, 2);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
